// File: rtl/uart_stream_arbiter.sv
// Shares one byte-wide UART transmitter between a buffered 16-bit sample stream
// and a status byte stream, framing each item as a sync-headed packet.
module uart_stream_arbiter #(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] SYNC_SAMPLE = 8'hA5,
  parameter logic [7:0] SYNC_STATUS = 8'h5A,
  parameter int         MAX_RUN     = 8,
  parameter int         BUSY_WAIT   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   sample_in,
  input  logic                          sample_valid,
  input  logic [7:0]                    status_in,
  input  logic                          status_req,
  output logic                          status_ack,
  output logic [7:0]                    uart_data,
  output logic                          uart_send,
  input  logic                          uart_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    overflow_count,
  output logic                          frame_active
);

  // state      | meaning
  // IDLE       | arbitrate between sample FIFO and status request
  // WAIT_START | send pulse issued, waiting for uart_busy to rise or timeout
  // WAIT_DONE  | byte in flight, waiting for uart_busy to fall

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = $clog2(MAX_RUN + 1);
  localparam int WW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE} state_t;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  state_t        state, state_nxt;
  logic [RW-1:0] run_cnt, run_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [1:0]    byte_idx, idx_nxt, last_idx;
  logic          is_sample, is_sample_nxt;
  logic [15:0]   sample_buf, sample_buf_nxt;
  logic [7:0]    status_buf, status_buf_nxt;
  logic [7:0]    data_nxt;
  logic          send_nxt, ack_nxt, frame_nxt;
  logic          sample_grant, status_grant;

  // Space is judged on start-of-cycle occupancy, so a same-cycle pop never admits a push.
  assign push = sample_valid && (fifo_level < LW'(FIFO_DEPTH));
  assign pop  = sample_grant;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      overflow_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase
      if (sample_valid && !push && overflow_count != 8'hFF)
        overflow_count <= overflow_count + 8'd1;
    end
  end

  assign last_idx = is_sample ? 2'd2 : 2'd1;

  always_comb begin
    state_nxt      = state;
    run_nxt        = run_cnt;
    wait_nxt       = wait_cnt;
    idx_nxt        = byte_idx;
    is_sample_nxt  = is_sample;
    sample_buf_nxt = sample_buf;
    status_buf_nxt = status_buf;
    data_nxt       = uart_data;
    send_nxt       = 1'b0;
    ack_nxt        = 1'b0;
    frame_nxt      = frame_active;
    sample_grant   = 1'b0;
    status_grant   = 1'b0;

    case (state)
      IDLE: begin
        if (fifo_level != '0 && (!status_req || run_cnt < RW'(MAX_RUN))) begin
          sample_grant   = 1'b1;
          sample_buf_nxt = mem[rd_ptr];
          is_sample_nxt  = 1'b1;
          data_nxt       = SYNC_SAMPLE;
          if (run_cnt < RW'(MAX_RUN)) run_nxt = run_cnt + RW'(1);
        end else if (status_req) begin
          status_grant   = 1'b1;
          status_buf_nxt = status_in;
          is_sample_nxt  = 1'b0;
          data_nxt       = SYNC_STATUS;
          ack_nxt        = 1'b1;
          run_nxt        = '0;
        end
        if (sample_grant || status_grant) begin
          send_nxt  = 1'b1;
          idx_nxt   = 2'd0;
          frame_nxt = 1'b1;
          wait_nxt  = WW'(BUSY_WAIT - 1);
          state_nxt = WAIT_START;
        end
      end
      WAIT_START: begin
        // Timeout path covers a transmitter whose busy is too fast to observe.
        if (uart_busy || wait_cnt == '0) state_nxt = WAIT_DONE;
        else                             wait_nxt  = wait_cnt - WW'(1);
      end
      WAIT_DONE: begin
        if (!uart_busy) begin
          if (byte_idx != last_idx) begin
            idx_nxt   = byte_idx + 2'd1;
            if (!is_sample)           data_nxt = status_buf;
            else if (byte_idx == 2'd0) data_nxt = sample_buf[15:8];
            else                       data_nxt = sample_buf[7:0];
            send_nxt  = 1'b1;
            wait_nxt  = WW'(BUSY_WAIT - 1);
            state_nxt = WAIT_START;
          end else begin
            frame_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      run_cnt      <= '0;
      wait_cnt     <= '0;
      byte_idx     <= '0;
      is_sample    <= 1'b0;
      sample_buf   <= '0;
      status_buf   <= '0;
      uart_data    <= '0;
      uart_send    <= 1'b0;
      status_ack   <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      state        <= state_nxt;
      run_cnt      <= run_nxt;
      wait_cnt     <= wait_nxt;
      byte_idx     <= idx_nxt;
      is_sample    <= is_sample_nxt;
      sample_buf   <= sample_buf_nxt;
      status_buf   <= status_buf_nxt;
      uart_data    <= data_nxt;
      uart_send    <= send_nxt;
      status_ack   <= ack_nxt;
      frame_active <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_uart_stream_arbiter.sv
// Directed bench for uart_stream_arbiter: a level/overflow vector table plus
// hand sequences for packet framing, starvation guard, busy timeout and reset.
module tb_uart_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [7:0]  status_in = '0;
  logic        status_req = 1'b0;
  logic        status_ack;
  logic [7:0]  uart_data;
  logic        uart_send;
  logic        uart_busy = 1'b0;
  logic [2:0]  fifo_level;
  logic [7:0]  overflow_count;
  logic        frame_active;

  uart_stream_arbiter dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .status_in(status_in), .status_req(status_req), .status_ack(status_ack),
    .uart_data(uart_data), .uart_send(uart_send), .uart_busy(uart_busy),
    .fifo_level(fifo_level), .overflow_count(overflow_count),
    .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Byte monitor, sampled mid-cycle
  logic [7:0] bytes[$];
  int         send_cyc[$];
  int         cyc = 0;
  int         ack_cnt = 0;
  int         wide_cnt = 0;
  logic       prev_send = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (uart_send === 1'b1) begin
      bytes.push_back(uart_data);
      send_cyc.push_back(cyc);
      if (prev_send) wide_cnt++;
    end
    prev_send = (uart_send === 1'b1);
    if (status_ack === 1'b1) ack_cnt++;
  end

  // Transmitter model: 0 = busy tied low, 1 = rises a cycle after send and holds 10, 2 = held high
  int busy_mode = 0;
  int busy_cnt  = 0;
  bit busy_pend = 1'b0;

  always @(negedge clk) begin
    if (busy_mode == 1) begin
      if (busy_pend) begin
        busy_cnt  = 10;
        busy_pend = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      if (uart_send === 1'b1) busy_pend = 1'b1;
      uart_busy = (busy_cnt != 0);
    end else begin
      busy_cnt  = 0;
      busy_pend = 1'b0;
      uart_busy = (busy_mode == 2);
    end
  end

  task automatic clear_mon();
    bytes.delete();
    send_cyc.delete();
    ack_cnt  = 0;
    wide_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int nbytes, input int budget);
    int t = 0;
    while ((bytes.size() < nbytes || frame_active !== 1'b0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({name, "_in_time"}, int'(t < budget), 1);
  endtask

  task automatic wait_ack(input string name, input int budget);
    int t = 0;
    while (status_ack !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({name, "_ack_in_time"}, int'(t < budget), 1);
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp[$]);
    check({name, "_nbytes"}, bytes.size(), exp.size());
    for (int i = 0; i < exp.size() && i < bytes.size(); i++)
      check($sformatf("%s_byte%0d", name, i), int'(bytes[i]), int'(exp[i]));
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_send"},  int'(uart_send), 0);
    check({name, "_data"},  int'(uart_data), 0);
    check({name, "_ack"},   int'(status_ack), 0);
    check({name, "_level"}, int'(fifo_level), 0);
    check({name, "_ovf"},   int'(overflow_count), 0);
    check({name, "_frame"}, int'(frame_active), 0);
  endtask

  typedef struct {
    logic        valid;
    logic [15:0] data;
    int          exp_level;
    int          exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] exp[$];

    // Pushes with the FSM stalled: occupancy caps at 4, further pushes count as drops
    vecs[0] = '{1'b1, 16'h1111, 1, 0};
    vecs[1] = '{1'b1, 16'h2222, 2, 0};
    vecs[2] = '{1'b0, 16'hDEAD, 2, 0};
    vecs[3] = '{1'b1, 16'h3333, 3, 0};
    vecs[4] = '{1'b1, 16'h4444, 4, 0};
    vecs[5] = '{1'b1, 16'h5555, 4, 1};
    vecs[6] = '{1'b1, 16'h6666, 4, 2};
    vecs[7] = '{1'b0, 16'hBEEF, 4, 2};

    // Reset state
    tick(2);
    check_zero_outputs("reset");
    rst = 1'b1;
    tick(2);

    // Single sample
    clear_mon();
    busy_mode = 1;
    push(16'h1234);
    wait_done("single", 3, 300);
    exp = '{8'hA5, 8'h12, 8'h34};
    check_bytes("single", exp);
    check("single_wide_pulses", wide_cnt, 0);
    check("single_level", int'(fifo_level), 0);
    check("single_frame", int'(frame_active), 0);
    check("single_no_ack", ack_cnt, 0);

    // Status only
    clear_mon();
    status_in  = 8'h3C;
    status_req = 1'b1;
    wait_ack("status", 20);
    status_req = 1'b0;
    wait_done("status", 2, 300);
    tick(10);
    exp = '{8'h5A, 8'h3C};
    check_bytes("status", exp);
    check("status_ack_count", ack_cnt, 1);
    check("status_wide_pulses", wide_cnt, 0);

    // Busy never rises: each byte advances on the BUSY_WAIT timeout
    clear_mon();
    busy_mode = 0;
    push(16'hABCD);
    wait_done("nobusy", 3, 300);
    exp = '{8'hA5, 8'hAB, 8'hCD};
    check_bytes("nobusy", exp);
    if (send_cyc.size() >= 3) begin
      check("nobusy_gap0", send_cyc[1] - send_cyc[0], 5);
      check("nobusy_gap1", send_cyc[2] - send_cyc[1], 5);
    end

    // Overflow: stall the FSM inside a status packet, then apply the vector table
    clear_mon();
    busy_mode  = 2;
    status_in  = 8'h77;
    status_req = 1'b1;
    wait_ack("ovf_stall", 20);
    status_req = 1'b0;
    tick(3);
    for (int i = 0; i < 8; i++) begin
      sample_in    = vecs[i].data;
      sample_valid = vecs[i].valid;
      @(negedge clk);
      sample_valid = 1'b0;
      check($sformatf("vec%0d_level", i), int'(fifo_level), vecs[i].exp_level);
      check($sformatf("vec%0d_ovf", i), int'(overflow_count), vecs[i].exp_ovf);
    end
    busy_mode = 1;
    wait_done("ovf_drain", 14, 1500);
    exp = '{8'h5A, 8'h77, 8'hA5, 8'h11, 8'h11, 8'hA5, 8'h22, 8'h22,
            8'hA5, 8'h33, 8'h33, 8'hA5, 8'h44, 8'h44};
    check_bytes("ovf_drain", exp);

    // Overflow counter saturation, then reset clears the FIFO
    busy_mode  = 2;
    status_in  = 8'h11;
    status_req = 1'b1;
    wait_ack("sat_stall", 20);
    status_req = 1'b0;
    tick(2);
    sample_valid = 1'b1;
    for (int i = 0; i < 264; i++) begin
      sample_in = 16'(i);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    check("sat_level", int'(fifo_level), 4);
    check("sat_ovf", int'(overflow_count), 255);
    #2 rst = 1'b0;
    #1 check_zero_outputs("sat_reset");
    tick(2);
    rst = 1'b1;
    busy_mode = 1;
    clear_mon();
    tick(60);
    check("sat_after_reset_nbytes", bytes.size(), 0);

    // Starvation guard: 8 sample packets, one status packet, then the rest
    clear_mon();
    push(16'h10C0);
    status_in  = 8'hE7;
    status_req = 1'b1;
    fork
      begin
        for (int i = 1; i < 12; i++) begin
          int t = 0;
          while (fifo_level >= 3'd4 && t < 500) begin
            @(negedge clk);
            t++;
          end
          push({8'h10 + 8'(i), 8'hC0 + 8'(i)});
        end
      end
      begin
        wait_ack("starve", 2000);
        status_req = 1'b0;
      end
    join
    wait_done("starve", 38, 3000);
    exp.delete();
    for (int i = 0; i < 12; i++) begin
      if (i == 8) begin
        exp.push_back(8'h5A);
        exp.push_back(8'hE7);
      end
      exp.push_back(8'hA5);
      exp.push_back(8'h10 + 8'(i));
      exp.push_back(8'hC0 + 8'(i));
    end
    check_bytes("starve", exp);
    check("starve_ack_count", ack_cnt, 1);
    check("starve_wide_pulses", wide_cnt, 0);

    // Reset just after the MSB send pulse
    clear_mon();
    busy_mode = 1;
    push(16'h5678);
    begin
      int t = 0;
      while (bytes.size() < 2 && t < 300) begin
        @(negedge clk);
        t++;
      end
      check("midrst_msb_in_time", int'(t < 300), 1);
    end
    #2 rst = 1'b0;
    #1 check_zero_outputs("midrst");
    tick(2);
    rst = 1'b1;
    tick(60);
    exp = '{8'hA5, 8'h56};
    check_bytes("midrst", exp);
    check("midrst_frame", int'(frame_active), 0);
    check("midrst_ovf", int'(overflow_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_stream_arbiter.md
Name: uart_stream_arbiter

Overview:
- Schedules the single byte-wide UART transmitter between two requesters: the audio sample stream (16-bit words) and a status/debug byte stream.
- Frames each item as a packet so the PC can resynchronise:
  - Sample packet = SYNC_SAMPLE, MSB, LSB.
  - Status packet = SYNC_STATUS, status byte.
- Buffers samples in a small FIFO, gives samples priority, and applies a starvation guard so status bytes still get through.
- Sits between the sample-valid generator and uart_transmit, replacing ad-hoc 2-byte send logic.

Parameters:
- FIFO_DEPTH, 4, sample FIFO entries; power of 2, minimum 2.
- SYNC_SAMPLE, 8'hA5, header byte of a sample packet.
- SYNC_STATUS, 8'h5A, header byte of a status packet.
- MAX_RUN, 8, consecutive sample packets allowed while status_req is pending.
- BUSY_WAIT, 4, cycles to wait for uart_busy to rise after a send pulse.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst, input, 1, asynchronous active-low reset.
- sample_in, input, 16, signed audio sample.
- sample_valid, input, 1, one-cycle strobe; sample_in valid this cycle.
- status_in, input, 8, status byte; held stable while status_req is high.
- status_req, input, 1, level request; held until status_ack.
- status_ack, output, 1, one-cycle pulse when the status byte is captured.
- uart_data, output, 8, byte to the transmitter.
- uart_send, output, 1, one-cycle send pulse to the transmitter.
- uart_busy, input, 1, transmitter busy.
- fifo_level, output, log2(FIFO_DEPTH)+1, current sample FIFO occupancy.
- overflow_count, output, 8, dropped samples; saturates at 255.
- frame_active, output, 1, high from grant until the last byte completes.

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: uart_send=0, uart_data=0, status_ack=0, fifo_level=0, overflow_count=0, frame_active=0.
  - Internal: state=IDLE, run_cnt=0, FIFO pointers=0.
- Reset mid-packet aborts the packet. No partial byte is re-sent after release.
- FIFO push:
  - On sample_valid, if occupancy < FIFO_DEPTH at the start of the cycle, write sample_in.
  - Otherwise drop it and increment overflow_count (saturating).
  - A same-cycle pop does not free space for that cycle's push.
- FIFO read: FIFO is first-word-fall-through; the head is readable combinationally.
- FSM has three states: IDLE, WAIT_START, WAIT_DONE.
- IDLE arbitration, evaluated every cycle:
  - Sample grant: FIFO non-empty AND (status_req=0 OR run_cnt < MAX_RUN).
    - Pop the head into a 16-bit buffer; run_cnt++ (saturating at MAX_RUN).
  - Else status grant: status_req=1.
    - Capture status_in; pulse status_ack; run_cnt=0.
  - On either grant:
    - Register uart_data=header and uart_send=1, visible the cycle after grant.
    - Set byte index=0, frame_active=1, go to WAIT_START.
- WAIT_START:
  - uart_send returns to 0 (pulse width exactly 1 cycle).
  - Go to WAIT_DONE when uart_busy=1, or when the wait counter reaches BUSY_WAIT cycles (covers a fast or combinational busy).
- WAIT_DONE, on uart_busy=0:
  - If bytes remain: advance the byte index, register the next uart_data, pulse uart_send, go to WAIT_START.
  - Sample byte order: MSB then LSB.
  - Otherwise: clear frame_active, go to IDLE.
- Packet spacing: at least one IDLE cycle between packets.
- uart_data holds its value until the next load.
- Simultaneous sample and status availability with run_cnt < MAX_RUN: the sample wins.
- A status_req that drops before grant is not an error; nothing is sent.
- The FIFO keeps accepting pushes while a packet is in flight.

Test Plan:
- Single sample: push 16'h1234, busy model rises 1 cycle after send and holds 10 cycles -> bytes A5, 12, 34; exactly three 1-cycle send pulses; fifo_level returns to 0; frame_active then 0.
- Status only: status_in=8'h3C, status_req=1 -> one status_ack pulse at grant; bytes 5A, 3C; status_ack not repeated after status_req drops.
- Starvation guard: keep FIFO non-empty with 12 samples queued, status_req held high -> exactly 8 sample packets, then one status packet, then the remaining samples resume.
- Overflow: FIFO_DEPTH=4 with busy held high; push 6 samples -> fifo_level=4, overflow_count=2; the first 4 samples are transmitted in order once busy is released.
- Busy never rises (uart_busy tied 0) -> each byte advances after BUSY_WAIT cycles; one sample packet completes in 3 pulses spaced ≥ BUSY_WAIT+1 cycles.
- Reset mid-packet: assert rst after the MSB send pulse -> all outputs 0 immediately (asynchronous); after release no LSB is sent; overflow_count=0.
